// File: rtl/lcd_reader_if.sv
// Request, result and LCD-pin bundle shared by the lcd_reader and whoever drives it.
// The reader takes the slave side; the requester/top level takes the master side.
interface lcd_reader_if;
  logic       iStart;
  logic       iRS;
  logic       iPoll;
  logic [7:0] iLCD_D;
  logic       oLCD_EN;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       oBusy;
  logic       oValid;
  logic [7:0] oData;
  logic       oBF;
  logic [6:0] oAddr;
  logic       oTimeout;

  modport slave (
    input  iStart, iRS, iPoll, iLCD_D,
    output oLCD_EN, oLCD_RS, oLCD_RW, oBusy, oValid, oData, oBF, oAddr, oTimeout
  );

  modport master (
    output iStart, iRS, iPoll, iLCD_D,
    input  oLCD_EN, oLCD_RS, oLCD_RW, oBusy, oValid, oData, oBF, oAddr, oTimeout
  );
endinterface

// File: rtl/lcd_reader.sv
// HD44780-style read cycle engine: single status/data reads, or status polling
// until the busy flag clears or the poll limit is reached.
module lcd_reader #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 16,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 8,
  parameter int POLL_MAX  = 4095
) (
  input logic         iCLK_50,
  input logic         iRST_N,
  lcd_reader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ENHI, S_HOLD, S_GAP, S_DONE
  } state_e;

  // Phase counter is loaded with (length-1) and the state ends when it reaches 0.
  localparam logic [4:0]  SETUP_LD = 5'(SETUP_CYC - 1);
  localparam logic [4:0]  EN_LD    = 5'(EN_CYC - 1);
  localparam logic [4:0]  HOLD_LD  = 5'(HOLD_CYC - 1);
  localparam logic [4:0]  GAP_LD   = 5'(GAP_CYC - 1);
  localparam logic [11:0] POLL_LIM = 12'(POLL_MAX);

  state_e      state_q, state_d;
  logic [4:0]  phase_q, phase_d;
  logic [11:0] poll_cnt_q, poll_cnt_d;
  logic        poll_q, poll_d;
  logic        rs_q, rs_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  data_q, data_d;
  logic        phase_last;

  assign phase_last = (phase_q == 5'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      phase_q    <= 5'd0;
      poll_cnt_q <= 12'd0;
      poll_q     <= 1'b0;
      rs_q       <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_cnt_q <= poll_cnt_d;
      poll_q     <= poll_d;
      rs_q       <= rs_d;
      timeout_q  <= timeout_d;
      data_q     <= data_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_last ? 5'd0 : phase_q - 5'd1;
    poll_cnt_d = poll_cnt_q;
    poll_d     = poll_q;
    rs_d       = rs_q;
    timeout_d  = timeout_q;
    data_d     = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          poll_d     = bus.iPoll;
          rs_d       = bus.iRS & ~bus.iPoll;
          timeout_d  = 1'b0;
          poll_cnt_d = 12'd0;
          phase_d    = SETUP_LD;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_last) begin
          phase_d = EN_LD;
          state_d = S_ENHI;
        end
      end
      S_ENHI: begin
        if (phase_last) begin
          data_d     = bus.iLCD_D;
          poll_cnt_d = poll_cnt_q + 12'd1;
          phase_d    = HOLD_LD;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (phase_last) begin
          phase_d = GAP_LD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (phase_last) begin
          if (poll_q && data_q[7]) begin
            if (poll_cnt_q < POLL_LIM) begin
              phase_d = SETUP_LD;
              state_d = S_SETUP;
            end else begin
              timeout_d = 1'b1;
              state_d   = S_DONE;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin outputs decode straight from the state register, so reset drops them at once.
  assign bus.oLCD_EN  = (state_q == S_ENHI);
  assign bus.oLCD_RW  = (state_q == S_SETUP) || (state_q == S_ENHI) || (state_q == S_HOLD);
  assign bus.oLCD_RS  = bus.oLCD_RW & rs_q;
  assign bus.oBusy    = (state_q != S_IDLE);
  assign bus.oValid   = (state_q == S_DONE);
  assign bus.oData    = data_q;
  assign bus.oBF      = data_q[7];
  assign bus.oAddr    = data_q[6:0];
  assign bus.oTimeout = timeout_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: a cycle-position model of each read
// transaction, one per-cycle compare process, and literal checks on key results.
module tb_lcd_reader;

  typedef struct packed {
    logic       en;
    logic       rw;
    logic       rs;
    logic       busy;
    logic       valid;
    logic       to;
    logic       bf;
    logic [6:0] addr;
    logic [7:0] data;
  } obs_t;

  localparam int PERIOD = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       rs = 1'b0;
  logic       poll = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] lcd_d = 8'h00;

  lcd_reader_if bus ();
  lcd_reader_if bus_t ();

  lcd_reader dut (.iCLK_50(clk), .iRST_N(rst_n), .bus(bus));
  lcd_reader #(.POLL_MAX(3)) dut_t (.iCLK_50(clk), .iRST_N(rst_n), .bus(bus_t));

  assign bus.iStart   = start & ~sel;
  assign bus.iRS      = rs;
  assign bus.iPoll    = poll;
  assign bus.iLCD_D   = lcd_d;
  assign bus_t.iStart = start & sel;
  assign bus_t.iRS    = rs;
  assign bus_t.iPoll  = poll;
  assign bus_t.iLCD_D = lcd_d;

  obs_t act_a, act_t, act;
  assign act_a = {bus.oLCD_EN, bus.oLCD_RW, bus.oLCD_RS, bus.oBusy, bus.oValid,
                  bus.oTimeout, bus.oBF, bus.oAddr, bus.oData};
  assign act_t = {bus_t.oLCD_EN, bus_t.oLCD_RW, bus_t.oLCD_RS, bus_t.oBusy, bus_t.oValid,
                  bus_t.oTimeout, bus_t.oBF, bus_t.oAddr, bus_t.oData};
  assign act   = sel ? act_t : act_a;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // LCD-side model: presents the next response byte each time EN rises.
  logic [7:0] resp[$];
  int         rd_idx = 0;
  logic       en_sel;
  assign en_sel = sel ? bus_t.oLCD_EN : bus.oLCD_EN;

  function automatic logic [7:0] resp_at(input int r);
    return resp[(r < resp.size()) ? r : resp.size() - 1];
  endfunction

  always @(posedge en_sel) begin
    lcd_d = resp_at(rd_idx);
    rd_idx++;
  end

  int valid_cnt_a = 0;
  always @(negedge clk) if (bus.oValid) valid_cnt_a++;

  // Expected per-cycle trace; entry c-1 holds cycle c after the accepting edge.
  obs_t exp_q[$];
  logic chk_on = 1'b0;
  int   cyc = 0;
  int   valid_at = -1;

  task automatic build_model(input logic m_rs, input logic m_poll, input int pmax,
                             input logic [7:0] prev, input int extra,
                             output int n, output logic [7:0] last);
    logic eff_rs, tmo;
    obs_t e;
    int r, p, k;
    n = 0;
    forever begin
      n++;
      if (!m_poll || !resp_at(n - 1)[7] || n == pmax) break;
    end
    tmo    = m_poll && resp_at(n - 1)[7];
    eff_rs = m_rs & ~m_poll;
    exp_q.delete();
    for (int c = 1; c <= PERIOD * n + extra; c++) begin
      e = '0;
      if (c <= PERIOD * n) begin
        r = (c - 1) / PERIOD;
        p = (c - 1) % PERIOD + 1;
        e.en = (p >= 3) && (p <= 18);
        e.rw = (p >= 1) && (p <= 20);
        e.rs = e.rw & eff_rs;
      end
      e.busy  = (c <= PERIOD * n + 1);
      e.valid = (c == PERIOD * n + 1);
      e.to    = tmo && (c >= PERIOD * n + 1);
      k = 0;
      for (int j = 0; j < n; j++) if (19 + PERIOD * j <= c) k = j + 1;
      e.data = (k == 0) ? prev : resp_at(k - 1);
      e.bf   = e.data[7];
      e.addr = e.data[6:0];
      exp_q.push_back(e);
    end
    last = resp_at(n - 1);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cyc++;
      check($sformatf("cyc%0d", cyc), 32'(act), 32'(exp_q[cyc - 1]));
      if (act.valid) valid_at = cyc;
      if (cyc == exp_q.size()) chk_on = 1'b0;
    end
  end

  logic [7:0] prev_a = 8'h00;
  logic [7:0] prev_t = 8'h00;

  task automatic run_txn(input logic t_sel, input logic t_rs, input logic t_poll,
                         input int pmax, input int extra, input int ignore_at);
    int n;
    logic [7:0] last;
    build_model(t_rs, t_poll, pmax, t_sel ? prev_t : prev_a, extra, n, last);
    @(posedge clk); #2;
    sel = t_sel; rs = t_rs; poll = t_poll; start = 1'b1; rd_idx = 0;
    @(posedge clk); #2;
    start = 1'b0; cyc = 0; valid_at = -1; chk_on = 1'b1;
    for (int i = 0; i < exp_q.size() + 10 && chk_on; i++) begin
      @(posedge clk); #2;
      start = (ignore_at > 0 && cyc == ignore_at - 1);
    end
    start = 1'b0;
    if (chk_on) begin
      check("trace_bound", 32'(cyc), 32'(exp_q.size()));
      chk_on = 1'b0;
    end
    if (t_sel) prev_t = last; else prev_a = last;
  endtask

  int vc;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_a", 32'(act_a), 32'h0);
    check("reset_t", 32'(act_t), 32'h0);
    rst_n = 1'b1;

    // Status read.
    resp = '{8'h25};
    run_txn(1'b0, 1'b0, 1'b0, 4095, 3, 0);
    check("status_valid_at", 32'(valid_at), 32'd29);
    check("status_data", 32'(bus.oData), 32'h25);
    check("status_addr", 32'(bus.oAddr), 32'h25);
    check("status_bf", 32'(bus.oBF), 32'h0);
    check("status_reads", 32'(rd_idx), 32'd1);

    // Data read.
    resp = '{8'h41};
    run_txn(1'b0, 1'b1, 1'b0, 4095, 3, 0);
    check("data_valid_at", 32'(valid_at), 32'd29);
    check("data_data", 32'(bus.oData), 32'h41);

    // Poll succeeds on the fourth read.
    resp = '{8'h80, 8'h80, 8'h80, 8'h07};
    run_txn(1'b0, 1'b1, 1'b1, 4095, 3, 0);
    check("poll_valid_at", 32'(valid_at), 32'd113);
    check("poll_reads", 32'(rd_idx), 32'd4);
    check("poll_timeout", 32'(bus.oTimeout), 32'h0);
    check("poll_addr", 32'(bus.oAddr), 32'h07);

    // Poll times out with a limit of 3.
    resp = '{8'h80};
    run_txn(1'b1, 1'b0, 1'b1, 3, 3, 0);
    check("tmo_valid_at", 32'(valid_at), 32'd85);
    check("tmo_reads", 32'(rd_idx), 32'd3);
    check("tmo_flag", 32'(bus_t.oTimeout), 32'h1);
    check("tmo_bf", 32'(bus_t.oBF), 32'h1);
    resp = '{8'h12};
    run_txn(1'b1, 1'b0, 1'b0, 3, 3, 0);
    check("tmo_cleared", 32'(bus_t.oTimeout), 32'h0);

    // Protocol shape plus an iStart at cycle 10 that must be ignored.
    resp = '{8'h33};
    run_txn(1'b0, 1'b0, 1'b0, 4095, 6, 10);
    check("ignore_reads", 32'(rd_idx), 32'd1);
    check("ignore_valid_at", 32'(valid_at), 32'd29);

    // Reset in the middle of ENHI.
    resp = '{8'h55};
    @(posedge clk); #2;
    sel = 1'b0; rs = 1'b1; poll = 1'b0; start = 1'b1; rd_idx = 0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("rst_pre_en", 32'(bus.oLCD_EN), 32'h1);
    vc = valid_cnt_a;
    rst_n = 1'b0;
    #1;
    check("rst_en", 32'(bus.oLCD_EN), 32'h0);
    check("rst_rw_rs", 32'({bus.oLCD_RW, bus.oLCD_RS}), 32'h0);
    check("rst_busy", 32'(bus.oBusy), 32'h0);
    check("rst_data", 32'(bus.oData), 32'h00);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    check("rst_no_valid", 32'(valid_cnt_a - vc), 32'd0);
    prev_a = 8'h00;
    prev_t = 8'h00;
    resp = '{8'h5A};
    run_txn(1'b0, 1'b0, 1'b0, 4095, 3, 0);
    check("rst_fresh_valid_at", 32'(valid_at), 32'd29);
    check("rst_fresh_data", 32'(bus.oData), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
